pipeline_sequencer: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the load-use hazard indication, the ID-stage taken-branch indication and a multi-cycle data-memory handshake. Produces one consistent set of PC, IF/ID and pipeline-register enables, flushes and bubbles. Sits beside the hazard detection logic and drives every pipeline register and the PC.

---
 rtl/pipeline_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, taken-branch and data-memory wait.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush/memory-wait performance counters.
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       load_use_i,
    input  logic       branch_taken_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ack_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_bubble_o,
    output logic       pipe_hold_o,
    output logic       dmem_req_o,
    output logic       timeout_o,
    output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_ERROR    = 2'b11
    } state_t;

    if (CNT_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_param_check
        $error("pipeline_sequencer: parameter out of range");
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           timeout_q, timeout_d;
    logic           grant_s;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= {CW{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic and Mealy outputs; grant_s means the pipeline may move this cycle.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        grant_s       = 1'b0;
        dmem_req_o    = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    dmem_req_o = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = {CW{1'b0}};
                end else begin
                    grant_s    = 1'b1;
                    dmem_req_o = dmem_req_i;
                    if (start_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    grant_s = 1'b1;
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    state_d    = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load-use outranks a taken branch; the branch re-resolves after the stall.
        if (grant_s) begin
            pipe_hold_o = 1'b0;
            if (load_use_i) begin
                idex_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
            end
        end else begin
            pipe_hold_o = 1'b1;
        end

        timeout_d = timeout_q | (state_d == ST_ERROR);
    end

    assign timeout_o = timeout_q;
    assign state_o   = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
            memwait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (state_q == ST_RUN && idex_bubble_o && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (ifid_flush_o && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
            if (state_q == ST_MEM_WAIT && !dmem_ack_i && memwait_cnt_q != CNT_MAX) begin
                memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
            end else begin
                memwait_cnt_q <= memwait_cnt_q;
            end
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a rule-level model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_sequencer;
    localparam int MT    = 8;
    localparam int CNT_W = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0, load_use_i = 1'b0, branch_taken_i = 1'b0;
    logic dmem_req_i = 1'b0, dmem_ack_i = 1'b0;
    logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o;
    logic dmem_req_o, timeout_o;
    logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
    int m_stall = 0, m_flush = 0, m_memwait = 0;
`endif

    always #5 clk_i = ~clk_i;

    pipeline_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_use_i(load_use_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_hold_o(pipe_hold_o), .dmem_req_o(dmem_req_o),
        .timeout_o(timeout_o), .state_o(state_o)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .memwait_cnt_o(memwait_cnt_o)
`endif
    );

    // expected vector: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, dmem_req, timeout, state[1:0]}
    logic [8:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // model: 0 idle, 1 running, 2 waiting on memory, 3 error; waited = memory cycles without ack
    int m_mode = 0;
    int m_waited = 0;

    task automatic cycle(input bit rst, input bit st, input bit lu, input bit br,
                         input bit rq, input bit ak);
        bit pc, iw, fl, bb, hd, dq, go;
        int cur;
        @(posedge clk_i);
        #1;
        rst_i = rst; start_i = st; load_use_i = lu; branch_taken_i = br;
        dmem_req_i = rq; dmem_ack_i = ak;
        pc = 0; iw = 0; fl = 0; bb = 0; hd = 1; dq = 0; go = 0;
        if (!rst) begin
            m_mode = 0;
            m_waited = 0;
            cur = 0;
`ifdef PIPE_PERF_CNT_EN
            m_stall = 0; m_flush = 0; m_memwait = 0;
`endif
        end else begin
            cur = m_mode;
            if (cur == 0) begin
                if (st) m_mode = 1;
            end else if (cur == 1) begin
                if (rq && !ak) begin
                    dq = 1; m_mode = 2; m_waited = 0;
                end else begin
                    go = 1; dq = rq; m_mode = st ? 1 : 0;
                end
            end else if (cur == 2) begin
                dq = 1;
                if (ak) begin
                    go = 1; m_mode = 1;
                end else begin
                    m_waited++;
`ifdef PIPE_PERF_CNT_EN
                    m_memwait++;
`endif
                    if (m_waited == MT) m_mode = 3;
                end
            end
        end
        if (go) begin
            hd = 0;
            if (lu) bb = 1;
            else if (br) begin pc = 1; iw = 1; fl = 1; end
            else begin pc = 1; iw = 1; end
        end
`ifdef PIPE_PERF_CNT_EN
        if (rst && cur == 1 && bb) m_stall++;
        if (rst && fl) m_flush++;
`endif
        exp_q.push_back({pc, iw, fl, bb, hd, dq, (cur == 3), 2'(cur)});
    endtask

    // Monitor: one output set per cycle, compared mid-cycle.
    always @(negedge clk_i) begin
        logic [8:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
                 dmem_req_o, timeout_o, state_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t {pc,ifw,fl,bb,hold,req,to,st} got=%b expected=%b",
                         $time, a, e);
            end
        end
    end

    initial begin
        // reset, start in cycle 2
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 1, 1);
        // miss released by ack after 4 freeze cycles
        cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 1, 0);
        cycle(1, 1, 0, 1, 1, 1);
        cycle(1, 1, 0, 0, 0, 0);
        // ack in the counter's final cycle wins over timeout
        cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < MT - 1; i++) cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 1, 1, 0, 1, 1);
        // timeout into error, held until reset
        cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < MT + 4; i++) cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 0);
        // async reset during the 3rd memory-wait cycle
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0, 0);
        // 3 load-use stalls, 2 branches and a 5-cycle miss
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, 1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d expected=0", exp_q.size());
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt_o !== CNT_W'(m_stall)) begin
            errors++;
            $display("FAIL stall_cnt got=%0d expected=%0d", stall_cnt_o, m_stall);
        end
        checks++;
        if (flush_cnt_o !== CNT_W'(m_flush)) begin
            errors++;
            $display("FAIL flush_cnt got=%0d expected=%0d", flush_cnt_o, m_flush);
        end
        checks++;
        if (memwait_cnt_o !== CNT_W'(m_memwait)) begin
            errors++;
            $display("FAIL memwait_cnt got=%0d expected=%0d", memwait_cnt_o, m_memwait);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
